// File: rtl/alu_pkg.sv
// Shared ALU operation codes and RISC-V major opcodes, used by the decode stage and the ALU.
package alu_pkg;

    localparam int unsigned OpcodeLength = 4;

    typedef logic [OpcodeLength-1:0] alu_op_t;

    localparam alu_op_t AluAnd  = 4'b0000;
    localparam alu_op_t AluOr   = 4'b0001;
    localparam alu_op_t AluAdd  = 4'b0010;
    localparam alu_op_t AluSub  = 4'b0011;
    localparam alu_op_t AluXor  = 4'b0100;
    localparam alu_op_t AluSll  = 4'b0101;
    localparam alu_op_t AluSrl  = 4'b0110;
    localparam alu_op_t AluSra  = 4'b0111;
    localparam alu_op_t AluEq   = 4'b1000;
    localparam alu_op_t AluSlt  = 4'b1001;
    localparam alu_op_t AluSltu = 4'b1010;
    localparam alu_op_t AluNe   = 4'b1011;

    localparam logic [6:0] OpcRType  = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    // Operations available when the extended operation set is disabled.
    function automatic logic is_base_op(alu_op_t op);
        return (op == AluAnd) || (op == AluOr) || (op == AluAdd) ||
               (op == AluSub) || (op == AluEq);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction-field to ALU operation decode.
// Define ALU_EXT_OPS_EN to enable XOR, shifts, SLT/SLTU and NE; otherwise they decode illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    operation,
    output logic       illegal
);

`ifdef ALU_EXT_OPS_EN
    localparam bit ExtEn = 1'b1;
`else
    localparam bit ExtEn = 1'b0;
`endif

    alu_op_t raw_op;
    logic    raw_ill;

    always_comb begin
        raw_op  = AluAnd;
        raw_ill = 1'b0;
        case (opcode)
            OpcRType: begin
                if (funct3 == 3'b000 && funct7 == Funct7Alt) begin
                    raw_op = AluSub;
                end else if (funct3 == 3'b101 && funct7 == Funct7Alt) begin
                    raw_op = AluSra;
                end else if (funct7 != Funct7Zero) begin
                    raw_ill = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  raw_op = AluAdd;
                        3'b001:  raw_op = AluSll;
                        3'b010:  raw_op = AluSlt;
                        3'b011:  raw_op = AluSltu;
                        3'b100:  raw_op = AluXor;
                        3'b101:  raw_op = AluSrl;
                        3'b110:  raw_op = AluOr;
                        default: raw_op = AluAnd;
                    endcase
                end
            end
            OpcIAlu: begin
                // funct7 is immediate data except for the shift encodings.
                case (funct3)
                    3'b000: raw_op = AluAdd;
                    3'b010: raw_op = AluSlt;
                    3'b011: raw_op = AluSltu;
                    3'b100: raw_op = AluXor;
                    3'b110: raw_op = AluOr;
                    3'b111: raw_op = AluAnd;
                    3'b001: begin
                        if (funct7 == Funct7Zero) raw_op = AluSll;
                        else                      raw_ill = 1'b1;
                    end
                    default: begin
                        if (funct7 == Funct7Zero)     raw_op = AluSrl;
                        else if (funct7 == Funct7Alt) raw_op = AluSra;
                        else                          raw_ill = 1'b1;
                    end
                endcase
            end
            OpcLoad, OpcStore, OpcJal, OpcJalr, OpcLui, OpcAuipc: begin
                raw_op = AluAdd;
            end
            OpcBranch: begin
                if (funct3 == 3'b000)      raw_op = AluEq;
                else if (funct3 == 3'b001) raw_op = AluNe;
                else                       raw_ill = 1'b1;
            end
            default: raw_ill = 1'b1;
        endcase
    end

    always_comb begin
        illegal   = raw_ill || (!ExtEn && !is_base_op(raw_op));
        operation = illegal ? AluAnd : raw_op;
    end

endmodule

// File: rtl/alu_op_stage.sv
// Registered decode stage: valid/ready handshake, ALU operation register and
// saturating illegal-instruction counter. ALU_EXT_OPS_EN selects the extended op set.
module alu_op_stage
    import alu_pkg::*;
#(
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_illegal,
    output logic [CNT_WIDTH-1:0]     illegal_count
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    alu_op_t dec_op;
    logic    dec_ill;
    logic    accept;

    logic                     valid_d, valid_q;
    logic [OPCODE_LENGTH-1:0] op_d, op_q;
    logic                     ill_d, ill_q;
    logic [CNT_WIDTH-1:0]     cnt_d, cnt_q;

    alu_op_decode u_decode (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .operation (dec_op),
        .illegal   (dec_ill)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        // Flush wins over accept; payload registers hold their last values.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op_d    = OPCODE_LENGTH'(dec_op);
            ill_d   = dec_ill;
            if (dec_ill && cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign Operation     = op_q;
    assign out_illegal   = ill_q;
    assign illegal_count = cnt_q;

endmodule
